// File: rtl/forward_hazard_unit_pkg.sv
// Shared processor definitions: operand-forward select encodings and the
// pipeline shadow-entry record used by the forwarding/hazard logic.
package forward_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Destination fields are held at a fixed maximum width so the record
    // layout is shared regardless of the instantiating ADDR_W (ADDR_W <= 16).
    localparam int DEST_W_MAX = 16;
    typedef logic [DEST_W_MAX-1:0] dest_t;

    typedef struct packed {
        logic  valid;
        logic  regwrite;
        logic  memread;
        dest_t dest;
    } stage_entry_t;

    // True when the entry will write a non-zero register equal to src.
    function automatic logic writes_src(input stage_entry_t e, input dest_t src);
        return e.valid && e.regwrite && (e.dest != '0) && (e.dest == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Picks the operand source for one EX-stage mux: the MEM result has priority
// over the WB result, otherwise the register file value is used.
module fwd_select
    import forward_hazard_unit_pkg::*;
(
    input  logic         ex_valid,
    input  dest_t        src,
    input  stage_entry_t mem_entry,
    input  stage_entry_t wb_entry,
    output logic [1:0]   sel
);

    // memread only matters for the EX entry; it is carried here for layout only.
    logic unused_memread;
    assign unused_memread = mem_entry.memread ^ wb_entry.memread;

    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (writes_src(mem_entry, src)) begin
                sel = FWD_MEM;
            end else if (writes_src(wb_entry, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard detection: shadows the EX/MEM/WB stages,
// derives the EX operand mux selects and a single-cycle load-use stall.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    input  logic [ADDR_W-1:0] ID_WriteReg,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_Valid,
    input  logic              Flush,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    stage_entry_t      ex_reg, mem_reg, wb_reg;
    stage_entry_t      ex_next;
    logic [ADDR_W-1:0] ex_rs_reg, ex_rt_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              stall;
    logic              bubble;
    dest_t             ex_src [2];
    logic [1:0]        fwd_sel [2];

    // A load in EX whose result is needed by ID cannot be forwarded in time.
    always_comb begin
        stall = ID_Valid && ex_reg.valid && ex_reg.memread && (ex_reg.dest != '0) &&
                ((ex_reg.dest == dest_t'(ID_Rs)) || (ex_reg.dest == dest_t'(ID_Rt)));
    end

    always_comb begin
        bubble  = stall || Flush || !ID_Valid;
        ex_next = '0;
        if (!bubble) begin
            ex_next.valid    = 1'b1;
            ex_next.regwrite = ID_RegWrite;
            ex_next.memread  = ID_MemRead;
            ex_next.dest     = dest_t'(ID_WriteReg);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_reg        <= '0;
            mem_reg       <= '0;
            wb_reg        <= '0;
            ex_rs_reg     <= '0;
            ex_rt_reg     <= '0;
            stall_cnt_reg <= '0;
        end else begin
            wb_reg    <= mem_reg;
            mem_reg   <= ex_reg;
            ex_reg    <= ex_next;
            ex_rs_reg <= ID_Rs;
            ex_rt_reg <= ID_Rt;
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign ex_src[0] = dest_t'(ex_rs_reg);
    assign ex_src[1] = dest_t'(ex_rt_reg);

    // Index 0 drives operand A (rs), index 1 drives operand B (rt).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd_select (
                .ex_valid  (ex_reg.valid),
                .src       (ex_src[gi]),
                .mem_entry (mem_reg),
                .wb_entry  (wb_reg),
                .sel       (fwd_sel[gi])
            );
        end
    endgenerate

    assign ForwardA   = fwd_sel[0];
    assign ForwardB   = fwd_sel[1];
    assign Stall      = stall;
    assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: a queue-based model of in-flight
// instructions is checked every cycle, plus hand-computed literal checks.
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_WriteReg = '0;
    logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_Valid = 1'b0, Flush = 1'b0;
    logic [1:0]  ForwardA, ForwardB, fa_sat, fb_sat;
    logic        Stall, stall_sat;
    logic [15:0] StallCount;
    logic [2:0]  cnt_sat;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    forward_hazard_unit dut (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WriteReg(ID_WriteReg),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_Valid(ID_Valid), .Flush(Flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall), .StallCount(StallCount)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    forward_hazard_unit #(.ADDR_W(5), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WriteReg(ID_WriteReg),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_Valid(ID_Valid), .Flush(Flush),
        .ForwardA(fa_sat), .ForwardB(fb_sat), .Stall(stall_sat), .StallCount(cnt_sat)
    );

    // ---------------- model ----------------
    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int d;
        int rs;
        int rt;
    } ins_t;

    ins_t inflight[$];   // [0] = instruction in EX, [1] = MEM, [2] = WB
    int   cnt_full = 0;
    int   cnt_narrow = 0;

    function automatic ins_t at(input int i);
        ins_t none;
        none = '{v: 0, rw: 0, mr: 0, d: 0, rs: 0, rt: 0};
        if (i < inflight.size()) return inflight[i];
        return none;
    endfunction

    function automatic logic [1:0] exp_fwd(input int src);
        ins_t ex;
        ins_t p;
        ex = at(0);
        if (!ex.v || src == 0) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            p = at(age);
            if (p.v && p.rw && p.d == src) return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        ins_t ex;
        ex = at(0);
        return ID_Valid && ex.v && ex.mr && ex.d != 0 &&
               (ex.d == int'(ID_Rs) || ex.d == int'(ID_Rt));
    endfunction

    always @(posedge clk) begin
        ins_t n;
        bit   s;
        if (reset) begin
            s = exp_stall();
            if (s) begin
                if (cnt_full < 65535) cnt_full++;
                if (cnt_narrow < 7) cnt_narrow++;
            end
            n = '{v: 0, rw: 0, mr: 0, d: 0, rs: int'(ID_Rs), rt: int'(ID_Rt)};
            if (!(s || Flush || !ID_Valid)) begin
                n.v  = 1;
                n.rw = ID_RegWrite;
                n.mr = ID_MemRead;
                n.d  = int'(ID_WriteReg);
            end
            inflight.push_front(n);
            if (inflight.size() > 3) void'(inflight.pop_back());
        end
    end

    always @(negedge reset) begin
        inflight.delete();
        cnt_full   = 0;
        cnt_narrow = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model (inputs are stable at negedge).
    always @(negedge clk) begin
        chk("model_fwdA",      32'(ForwardA),   32'(exp_fwd(at(0).rs)));
        chk("model_fwdB",      32'(ForwardB),   32'(exp_fwd(at(0).rt)));
        chk("model_stall",     32'(Stall),      32'(exp_stall()));
        chk("model_count",     32'(StallCount), 32'(cnt_full));
        chk("model_stall_sat", 32'(stall_sat),  32'(exp_stall()));
        chk("model_count_sat", 32'(cnt_sat),    32'(cnt_narrow));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input bit rw, input bit mr,
                       input int rs, input int rt, input int wd, input bit fl);
        @(posedge clk);
        #1;
        ID_Valid    = v;
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        ID_Rs       = 5'(rs);
        ID_Rt       = 5'(rt);
        ID_WriteReg = 5'(wd);
        Flush       = fl;
        $display("txn t=%0t v=%0d rw=%0d mr=%0d rs=%0d rt=%0d wd=%0d flush=%0d",
                 $time, v, rw, mr, rs, rt, wd, fl);
    endtask

    task automatic nop();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_fwdA", 32'(ForwardA), 0);
        chk("rst_fwdB", 32'(ForwardB), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_count", 32'(StallCount), 0);
        @(negedge clk);
        #2 reset = 1'b1;

        // add $8 ; add rs=$8
        cyc(1, 1, 0, 1, 2, 8, 0);
        cyc(1, 1, 0, 8, 3, 10, 0);
        nop();
        settle();
        chk("raw_mem_fwdA", 32'(ForwardA), 32'(2'b10));
        chk("raw_mem_fwdB", 32'(ForwardB), 32'(2'b00));

        // add $8 ; nop ; sub rt=$8
        cyc(1, 1, 0, 1, 2, 8, 0);
        nop();
        cyc(1, 1, 0, 4, 8, 11, 0);
        nop();
        settle();
        chk("raw_wb_fwdB", 32'(ForwardB), 32'(2'b01));

        // add $8 ; add $8 ; sub rt=$8 -> youngest (MEM) wins
        cyc(1, 1, 0, 1, 2, 8, 0);
        cyc(1, 1, 0, 3, 4, 8, 0);
        cyc(1, 1, 0, 5, 8, 11, 0);
        nop();
        settle();
        chk("mem_priority_fwdB", 32'(ForwardB), 32'(2'b10));

        // lw $9 ; add rs=$9 (held one cycle by the stall)
        cyc(1, 1, 1, 1, 0, 9, 0);
        cyc(1, 1, 0, 9, 2, 10, 0);
        settle();
        chk("loaduse_stall", 32'(Stall), 1);
        chk("loaduse_count0", 32'(StallCount), 0);
        cyc(1, 1, 0, 9, 2, 10, 0);
        settle();
        chk("loaduse_stall_drop", 32'(Stall), 0);
        chk("loaduse_count1", 32'(StallCount), 1);
        nop();
        settle();
        chk("loaduse_fwdA", 32'(ForwardA), 32'(2'b01));

        // writes and loads to $0, then $0 readers
        cyc(1, 1, 0, 1, 2, 0, 0);
        cyc(1, 1, 1, 3, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 12, 0);
        settle();
        chk("r0_stall", 32'(Stall), 0);
        nop();
        settle();
        chk("r0_fwdA", 32'(ForwardA), 0);
        chk("r0_fwdB", 32'(ForwardB), 0);

        // lw $9 ; dependent instruction flushed in the same cycle
        cyc(1, 1, 1, 1, 0, 9, 0);
        cyc(1, 1, 0, 9, 9, 10, 1);
        settle();
        chk("flush_stall", 32'(Stall), 1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("flush_bubble_fwdA", 32'(ForwardA), 0);
        chk("flush_bubble_fwdB", 32'(ForwardB), 0);
        chk("flush_count", 32'(StallCount), 2);

        // MEM/WB valid with a pending stall, then asynchronous reset mid-cycle
        cyc(1, 1, 0, 1, 2, 12, 0);
        cyc(1, 1, 0, 1, 2, 13, 0);
        cyc(1, 1, 1, 12, 13, 14, 0);
        cyc(1, 1, 0, 14, 0, 15, 0);
        settle();
        chk("pre_rst_fwdA", 32'(ForwardA), 32'(2'b01));
        chk("pre_rst_fwdB", 32'(ForwardB), 32'(2'b10));
        chk("pre_rst_stall", 32'(Stall), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_fwdA", 32'(ForwardA), 0);
        chk("async_rst_fwdB", 32'(ForwardB), 0);
        chk("async_rst_stall", 32'(Stall), 0);
        chk("async_rst_count", 32'(StallCount), 0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("post_rst_stall", 32'(Stall), 0);
        nop();
        settle();
        chk("post_rst_fwdA", 32'(ForwardA), 0);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 1, 1, 0, 9, 0);
            cyc(1, 1, 0, 9, 2, 10, 0);
            cyc(1, 1, 0, 9, 2, 10, 0);
        end
        nop();
        settle();
        chk("sat_count_narrow", 32'(cnt_sat), 7);
        chk("sat_count_full", 32'(StallCount), 9);

        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
